upscale_simd: RTL and testbench

Bilinear upscaler, the inverse path of the SIMD downscaler. It takes an SRC_H x SRC_W 8-bit grayscale frame and produces a DST_H x DST_W frame using corner-aligned bilinear interpolation. N parallel lanes compute N output pixels of one row per cycle. It sits beside the downscaler and uses the same start/done, full-frame array interface.

---
 rtl/scale_pkg.sv | 23 ++
 rtl/bilinear_lane.sv | 40 ++++
 rtl/upscale_simd.sv | 143 ++++++++++++++
 tb/tb_upscale_simd.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared types and elaboration-time helpers for the bilinear scaler family.
package scale_pkg;

   typedef logic [7:0] pixel_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPUTE,
      S_DONE
   } state_t;

   localparam int FRAC_DEF = 12;

   // Corner-aligned step between destination samples, in source pixels, FRAC fraction bits.
   function automatic int ratio_fx(input int src, input int dst, input int frac);
      return ((src - 1) << frac) / (dst - 1);
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/bilinear_lane.sv
// One combinational bilinear interpolation lane: horizontal pass, vertical pass,
// then round-half-up and saturate back to 8 bits.
module bilinear_lane
   import scale_pkg::*;
#(
   parameter int FRAC = FRAC_DEF
) (
   input  pixel_t          a,
   input  pixel_t          b,
   input  pixel_t          c0,
   input  pixel_t          d,
   input  logic [FRAC-1:0] xw,
   input  logic [FRAC-1:0] yw,
   output pixel_t          pix
);

   localparam int TOP_W = 8 + FRAC + 1;
   localparam int ACC_W = 8 + 2 * FRAC + 1;
   localparam logic [FRAC:0] ONE = {1'b1, {FRAC{1'b0}}};

   function automatic pixel_t round_sat(input logic [ACC_W-1:0] acc_in);
      logic [ACC_W-1:0] q;
      q = (acc_in + (ACC_W'(1) << (2 * FRAC - 1))) >> (2 * FRAC);
      return (q > ACC_W'(255)) ? 8'hFF : q[7:0];
   endfunction

   logic [TOP_W-1:0] top;
   logic [TOP_W-1:0] bot;
   logic [ACC_W-1:0] acc;

   // Weights always sum to 2^FRAC, so flat regions reproduce exactly.
   always_comb begin
      top = TOP_W'(a)  * TOP_W'(ONE - {1'b0, xw}) + TOP_W'(b) * TOP_W'(xw);
      bot = TOP_W'(c0) * TOP_W'(ONE - {1'b0, xw}) + TOP_W'(d) * TOP_W'(xw);
      acc = ACC_W'(top) * ACC_W'(ONE - {1'b0, yw}) + ACC_W'(bot) * ACC_W'(yw);
   end

   assign pix = round_sat(acc);

endmodule

// File: rtl/upscale_simd.sv
// Bilinear frame upscaler: N lanes produce N pixels of one output row per cycle,
// writing straight into a registered full-frame output array.
module upscale_simd
   import scale_pkg::*;
#(
   parameter int SRC_H = 16,
   parameter int SRC_W = 16,
   parameter int DST_H = 32,
   parameter int DST_W = 32,
   parameter int N     = 4,
   parameter int FRAC  = FRAC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] image_in  [0:SRC_H-1][0:SRC_W-1],
   output logic       done,
   output logic [7:0] image_out [0:DST_H-1][0:DST_W-1]
);

   localparam int RX   = ratio_fx(SRC_W, DST_W, FRAC);
   localparam int RY   = ratio_fx(SRC_H, DST_H, FRAC);
   localparam int XI_W = $clog2(SRC_W);
   localparam int YI_W = $clog2(SRC_H);
   localparam int XS_W = XI_W + FRAC;
   localparam int YS_W = YI_W + FRAC;
   localparam int CB_W = $clog2(DST_W + N);
   localparam int RO_W = $clog2(DST_H);
   localparam int CO_W = $clog2(DST_W);

   state_t          state_q, state_d;
   logic [RO_W-1:0] r_q, r_d;
   logic [CB_W-1:0] cb_q, cb_d;
   logic            done_q, done_d;
   logic            wr_en;

   logic [YS_W-1:0] ys;
   logic [YI_W-1:0] y_l, y_h;

   logic            lane_mask [N];
   logic [CO_W-1:0] lane_idx  [N];
   pixel_t          lane_pix  [N];

   // Row coordinate is common to every lane in the group.
   assign ys  = YS_W'(r_q) * YS_W'(RY);
   assign y_l = ys[YS_W-1:FRAC];
   assign y_h = (y_l == YI_W'(SRC_H - 1)) ? y_l : y_l + 1'b1;

   for (genvar k = 0; k < N; k++) begin : g_lane
      logic [CB_W-1:0] col;
      logic [CB_W-1:0] col_s;
      logic [XS_W-1:0] xs;
      logic [XI_W-1:0] x_l, x_h;

      // Masked lanes fetch column 0 so the source index never leaves the frame.
      assign col          = cb_q + CB_W'(k);
      assign lane_mask[k] = (col >= CB_W'(DST_W));
      assign lane_idx[k]  = CO_W'(col);
      assign col_s        = lane_mask[k] ? '0 : col;
      assign xs           = XS_W'(col_s) * XS_W'(RX);
      assign x_l          = xs[XS_W-1:FRAC];
      assign x_h          = (x_l == XI_W'(SRC_W - 1)) ? x_l : x_l + 1'b1;

      bilinear_lane #(
         .FRAC (FRAC)
      ) u_lane (
         .a   (image_in[y_l][x_l]),
         .b   (image_in[y_l][x_h]),
         .c0  (image_in[y_h][x_l]),
         .d   (image_in[y_h][x_h]),
         .xw  (xs[FRAC-1:0]),
         .yw  (ys[FRAC-1:0]),
         .pix (lane_pix[k])
      );
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      cb_d    = cb_q;
      done_d  = done_q;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_COMPUTE;
               r_d     = '0;
               cb_d    = '0;
               done_d  = 1'b0;
            end
         end
         S_COMPUTE: begin
            wr_en = 1'b1;
            if (cb_q + CB_W'(N) >= CB_W'(DST_W)) begin
               cb_d = '0;
               if (r_q == RO_W'(DST_H - 1)) begin
                  r_d     = '0;
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  r_d = r_q + 1'b1;
               end
            end else begin
               cb_d = cb_q + CB_W'(N);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         cb_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         cb_q    <= cb_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DST_H; i++) begin
            for (int j = 0; j < DST_W; j++) begin
               image_out[i][j] <= '0;
            end
         end
      end else if (wr_en) begin
         for (int k = 0; k < N; k++) begin
            if (!lane_mask[k]) begin
               image_out[r_q][lane_idx[k]] <= lane_pix[k];
            end
         end
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_upscale_simd.sv
// Scoreboard bench for upscale_simd: a real-valued bilinear reference fills the
// expectation queue, and each completed frame is drained against it.
module tb_upscale_simd;

   localparam int SH  = 16;
   localparam int SW  = 16;
   localparam int DH  = 32;
   localparam int DW  = 32;
   localparam int FR  = 12;
   localparam int RXT = ((SW - 1) << FR) / (DW - 1);
   localparam int RYT = ((SH - 1) << FR) / (DH - 1);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start4 = 1'b0;
   logic       start3 = 1'b0;
   logic       done4, done3;
   logic [7:0] img  [0:SH-1][0:SW-1];
   logic [7:0] out4 [0:DH-1][0:DW-1];
   logic [7:0] out3 [0:DH-1][0:DW-1];

   typedef struct {
      int exp;
      int tol;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   upscale_simd #(
      .SRC_H (SH), .SRC_W (SW), .DST_H (DH), .DST_W (DW), .N (4), .FRAC (FR)
   ) dut4 (
      .clk       (clk),
      .rst       (rst),
      .start     (start4),
      .image_in  (img),
      .done      (done4),
      .image_out (out4)
   );

   upscale_simd #(
      .SRC_H (SH), .SRC_W (SW), .DST_H (DH), .DST_W (DW), .N (3), .FRAC (FR)
   ) dut3 (
      .clk       (clk),
      .rst       (rst),
      .start     (start3),
      .image_in  (img),
      .done      (done3),
      .image_out (out3)
   );

   task automatic chk(input string tag, input int obs, input int exp, input int tol);
      int diff;
      n_tests++;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   function automatic int ref_pix(input int r, input int c);
      int  xs, ys, xl, yl, xh, yh;
      real fx, fy, top, bot;
      xs  = c * RXT;
      ys  = r * RYT;
      xl  = xs >> FR;
      yl  = ys >> FR;
      xh  = (xl + 1 > SW - 1) ? SW - 1 : xl + 1;
      yh  = (yl + 1 > SH - 1) ? SH - 1 : yl + 1;
      fx  = real'(xs - (xl << FR)) / real'(1 << FR);
      fy  = real'(ys - (yl << FR)) / real'(1 << FR);
      top = real'(img[yl][xl]) * (1.0 - fx) + real'(img[yl][xh]) * fx;
      bot = real'(img[yh][xl]) * (1.0 - fx) + real'(img[yh][xh]) * fx;
      return $rtoi(top * (1.0 - fy) + bot * fy + 0.5);
   endfunction

   // 0: ramp, 1: constant 0x80, 2: checkerboard with 255 at the origin
   task automatic load(input int pat);
      for (int i = 0; i < SH; i++) begin
         for (int j = 0; j < SW; j++) begin
            case (pat)
               0:       img[i][j] = 8'((i * 8 + j * 4) & 255);
               1:       img[i][j] = 8'h80;
               default: img[i][j] = ((i + j) % 2 == 0) ? 8'hFF : 8'h00;
            endcase
         end
      end
   endtask

   task automatic push_ref(input int tol);
      exp_t e;
      for (int r = 0; r < DH; r++) begin
         for (int c = 0; c < DW; c++) begin
            e.exp = ref_pix(r, c);
            e.tol = tol;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_const(input int v);
      exp_t e;
      for (int i = 0; i < DH * DW; i++) begin
         e.exp = v;
         e.tol = 0;
         exp_q.push_back(e);
      end
   endtask

   function automatic int pix_of(input int sel, input int r, input int c);
      return (sel != 0) ? int'(out3[r][c]) : int'(out4[r][c]);
   endfunction

   function automatic int done_of(input int sel);
      return (sel != 0) ? int'(done3) : int'(done4);
   endfunction

   function automatic int nonzero(input int sel);
      int n = 0;
      for (int r = 0; r < DH; r++) begin
         for (int c = 0; c < DW; c++) begin
            if (pix_of(sel, r, c) != 0) n++;
         end
      end
      return n;
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel != 0) start3 = v;
      else          start4 = v;
   endtask

   task automatic drain(input int sel, input string tag);
      exp_t e;
      for (int r = 0; r < DH; r++) begin
         for (int c = 0; c < DW; c++) begin
            if (exp_q.size() == 0) begin
               chk({tag, "_queue_empty"}, 0, 1, 0);
               return;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d][%0d]", tag, r, c), pix_of(sel, r, c), e.exp, e.tol);
         end
      end
   endtask

   // Counts edges from the start-accepting edge to the edge that raises done.
   task automatic run_frame(input int sel, input int exp_cycles, input int start_at,
                            input int rst_at, input string tag);
      int n;
      int rst_pending;
      rst_pending = rst_at;
      @(negedge clk);
      set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      chk({tag, "_ack_done"}, done_of(sel), 0, 0);
      n = 0;
      while (n < 3000) begin
         @(posedge clk);
         n++;
         #1;
         if (done_of(sel) != 0) break;
         if (n == start_at) set_start(sel, 1'b1);
         else if (n == start_at + 1) set_start(sel, 1'b0);
         if (n == rst_pending) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk({tag, "_rst_done"}, done_of(sel), 0, 0);
            chk({tag, "_rst_nonzero"}, nonzero(sel), 0, 0);
            set_start(sel, 1'b1);
            @(posedge clk);
            #1;
            set_start(sel, 1'b0);
            n = 0;
            rst_pending = -1;
         end
      end
      chk({tag, "_latency"}, n, exp_cycles, 0);
   endtask

   initial begin
      load(0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_done4", int'(done4), 0, 0);
      chk("reset_done3", int'(done3), 0, 0);
      chk("reset_out4", nonzero(0), 0, 0);
      chk("reset_out3", nonzero(1), 0, 0);
      @(negedge clk);
      rst = 1'b0;

      push_ref(1);
      run_frame(0, 256, -1, -1, "ramp");
      chk("ramp_0_0", int'(out4[0][0]), 0, 0);
      chk("ramp_31_31", int'(out4[31][31]), 180, 1);
      drain(0, "ramp");

      load(1);
      push_const(128);
      run_frame(0, 256, -1, -1, "const");
      drain(0, "const");

      load(2);
      push_ref(1);
      run_frame(0, 256, -1, -1, "check");
      chk("check_0_0", int'(out4[0][0]), 255, 0);
      drain(0, "check");

      load(0);
      push_ref(1);
      run_frame(0, 256, 50, -1, "midstart");
      drain(0, "midstart");

      load(2);
      push_ref(1);
      run_frame(0, 256, -1, -1, "restart");
      drain(0, "restart");

      load(0);
      push_ref(1);
      run_frame(0, 256, -1, 100, "rstmid");
      drain(0, "rstmid");

      push_ref(1);
      run_frame(1, 352, -1, -1, "n3");
      drain(1, "n3");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
